// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified memory port between instruction fetch (read-only)
// and the data path (load/store). Simultaneous requests are arbitrated round-robin. Each access
// runs IDLE -> ACCESS -> RESP and finishes with a one-cycle ack pulse to its owner.
//
// Ports:
//   clk, rst_b            clock and synchronous active-high reset
//   if_req/if_addr        fetch request and address; if_rdata/if_ack fetch response
//   d_req/d_we/d_addr/
//   d_wdata               data request (d_we = 1 for store); d_rdata/d_ack data response
//   mem_addr              word-aligned address to memory
//   mem_data_in           store bytes to memory, byte 0 = word[31:24] (big-endian)
//   mem_data_out          read bytes from memory, same byte order
//   mem_write_en          write strobe, high only in a store's single ACCESS cycle
//   busy                  high whenever the arbiter is not idle
// All outputs are registered.
module mem_port_arbiter #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic [XLEN-1:0] mem_addr,
  output logic [0:3][7:0] mem_data_in,
  input  logic [0:3][7:0] mem_data_out,
  output logic            mem_write_en,
  output logic            busy
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAccess = 2'd1;
  localparam logic [1:0] StResp   = 2'd2;

  localparam logic GntFetch = 1'b0;
  localparam logic GntData  = 1'b1;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q, owner_d;
  logic            store_q, store_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            mem_we_q, mem_we_d;
  logic            if_ack_q, if_ack_d;
  logic            d_ack_q, d_ack_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            busy_q, busy_d;

  logic            grant_data;
  logic [XLEN-1:0] grant_addr;
  logic [31:0]     rd_word;

  // Byte 0 sits in the most significant lane of the packed array, giving big-endian order.
  assign rd_word = mem_data_out;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    store_d      = store_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_we_d     = 1'b0;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    busy_d       = busy_q;
    grant_data   = 1'b0;
    grant_addr   = if_addr;

    case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          // On a tie the side that did not win last time gets the port.
          grant_data   = d_req && (!if_req || (last_grant_q == GntFetch));
          grant_addr   = grant_data ? d_addr : if_addr;
          owner_d      = grant_data ? GntData : GntFetch;
          last_grant_d = owner_d;
          store_d      = grant_data && d_we;
          addr_d       = {grant_addr[XLEN-1:2], 2'b00};
          cnt_d        = CntW'(MEM_LATENCY - 1);
          if (grant_data && d_we) begin
            wdata_d  = d_wdata[31:0];
            mem_we_d = 1'b1;
          end
          state_d = StAccess;
          busy_d  = 1'b1;
        end
      end

      StAccess: begin
        // Stores take a single cycle; reads wait until the address has been held long enough.
        if (store_q || (cnt_q == '0)) begin
          state_d = StResp;
          if (owner_q == GntData) begin
            d_ack_d = 1'b1;
            if (!store_q) begin
              d_rdata_d = XLEN'(rd_word);
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = XLEN'(rd_word);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StResp: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      last_grant_q <= GntFetch;
      owner_q      <= GntFetch;
      store_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_we_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      store_q      <= store_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_we_q     <= mem_we_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_data_in  = wdata_q;
  assign mem_write_en = mem_we_q;
  assign if_ack       = if_ack_q;
  assign d_ack        = d_ack_q;
  assign if_rdata     = if_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign busy         = busy_q;

endmodule
